mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle combinational MIPS controller.
- Sequences each instruction through FETCH/DECODE/EXEC/MEMACC/WBACK with ready handshakes to instruction and data memory.
- Drives the same datapath control set plus PC/IR write enables.
- Adds an illegal-instruction trap, a memory-wait watchdog and a retired-instruction counter; sits between IR/datapath and the NPC, RF, ALU and DM units.

Parameters:
ALUCTR_W, 4, ALUctr width (codes zero-extended if wider)
NPCOP_W, 4, NPCop width
TIMEOUT, 16, max cycles waiting for imem_ready/dmem_ready before trap (>=1)
CNT_W, 32, retired_cnt width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
op  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access completes this cycle
imem_rd  out  1  instruction fetch request
dmem_rd  out  1  data read request
IRWr  out  1  load IR
PCWr  out  1  update PC with NPC result
RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp  out  1 each  datapath controls (single-cycle meanings)
ALUctr  out  ALUCTR_W  ALU op
NPCop  out  NPCOP_W  next-PC select
state  out  3  current FSM state
trap  out  1  sticky: illegal instruction or timeout
timeout  out  1  sticky: trap caused by watchdog
retired_cnt  out  CNT_W  instructions completed

Behaviour:
- Encodings. ALUctr: AND 0000, OR 0001, ADD 0010, XOR 0011, ORI 0100, ADDIU 0101, SUB 0110, SLT 0111, SLL 1000, LUI 1111. NPCop: JUMP 0000, BEQ 0010, ADD4 1111. States: FETCH 0, DECODE 1, EXEC 2, MEMACC 3, WBACK 4, TRAP 5.
- Reset (rst=1 at posedge):
  - state=FETCH; trap=timeout=0; retired_cnt=0; watchdog=0.
  - While rst=1, all enables (imem_rd, dmem_rd, IRWr, PCWr, RegWr, MemWr) are forced 0.
- Outputs are Moore functions of state and the latched decode, except:
  - PCWr/IRWr gate on the ready inputs;
  - NPCop in EXEC for beq depends on zero.
- Idle values: RegDst=ALUSrc=MemtoReg=ExtOp=0, ALUctr=ADD, NPCop=ADD4.
- FETCH:
  - imem_rd=1.
  - On imem_ready=1: IRWr=1, go DECODE.
  - Otherwise stay and increment watchdog.
- DECODE:
  - Register op/func into a decode latch; later states use only the latched copy.
  - Legal R-type funcs: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 101010 SLT, 000000 SLL.
  - Legal opcodes: 000000 R, 001000 addi, 001001 addiu, 001101 ori, 001111 lui, 100011 lw, 101011 sw, 000100 beq, 000010 j.
  - j: PCWr=1, NPCop=JUMP, retire, go FETCH.
  - Illegal op or func: go TRAP with trap=1.
  - All other legal instructions: go EXEC.
- EXEC: ALUctr/ALUSrc/ExtOp/RegDst held for the latched instruction.
  - R: RegDst=0, ALUSrc=0, ALUctr per func.
  - addi/addiu: RegDst=1, ALUSrc=1, ExtOp=1, ALUctr=ADDIU.
  - ori: ExtOp=0 (zero-extend), ALUctr=ORI.
  - lui: ExtOp=1, ALUctr=LUI.
  - lw/sw: RegDst=1, ALUSrc=1, ExtOp=1, ALUctr=ADD.
  - beq: ALUSrc=0, ALUctr=SUB, PCWr=1, NPCop=BEQ if zero=1 else ADD4; retire, go FETCH.
  - lw/sw go MEMACC; all others go WBACK.
- MEMACC: lw asserts dmem_rd=1; sw asserts MemWr=1. Both hold until dmem_ready.
  - lw on ready: go WBACK.
  - sw on ready: PCWr=1, NPCop=ADD4, retire, go FETCH.
  - Controls from EXEC are held stable throughout.
- WBACK:
  - RegWr=1, PCWr=1, NPCop=ADD4.
  - MemtoReg=1 for lw, else 0; RegDst and ALU controls held.
  - Retire, go FETCH.
- Retire: retired_cnt += 1 in the same cycle PCWr=1. Wraps modulo 2^CNT_W.
- Latency with zero wait states:
  - j: 2 cycles.
  - beq: 3 cycles.
  - ALU ops: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
- Watchdog:
  - Counts consecutive cycles in FETCH without imem_ready, or in MEMACC without dmem_ready.
  - Clears on state change.
  - When the count reaches TIMEOUT with ready still 0, go TRAP with trap=timeout=1.
  - A ready arriving in the same cycle the count reaches TIMEOUT wins (normal progress).
- TRAP: all enables 0, absorbing; only rst exits. retired_cnt frozen.
- Reset mid-instruction: abandon immediately. No PCWr/RegWr/MemWr in the reset cycle.

Test Plan:
- Reset, imem_ready=1, IR=add (op 000000, func 100000): states 0,1,2,4,0; RegWr=1 only in WBACK with RegDst=0, ALUctr=0010; retired_cnt=1.
- lw (op 100011), dmem_ready low for 3 MEMACC cycles then 1: dmem_rd held 4 cycles; WBACK has MemtoReg=1, RegWr=1; total 8 cycles; retired_cnt=1.
- beq with zero=1 then zero=0: EXEC PCWr=1 with NPCop=0010, then NPCop=1111; no RegWr/MemWr; 3 cycles each.
- j (op 000010): PCWr=1 with NPCop=0000 in DECODE; next FETCH in cycle 2.
- IR op=111111, then R func=001000: trap=1, state=5, all enables 0 indefinitely; rst returns state=0, trap=0.
- TIMEOUT=4, imem_ready held 0: trap=timeout=1 after 4 FETCH cycles. Repeat with ready asserted exactly at count 4: normal DECODE, no trap.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS controller: sequences FETCH/DECODE/EXEC/MEMACC/WBACK,
// drives datapath controls plus PC/IR write enables, traps on illegal
// instructions or memory-wait timeouts, and counts retired instructions.
//
// Handshake: imem_rd/dmem_rd/MemWr are requests held high for as long as the
// controller waits. A transfer completes in the cycle where the request is
// high and the matching *_ready input is high. IRWr and the sw-retire PCWr are
// asserted combinationally in that completing cycle only.
module mc_controller #(
  parameter int ALUCTR_W = 4,
  parameter int NPCOP_W  = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_rd,
  output logic                dmem_rd,
  output logic                IRWr,
  output logic                PCWr,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWr,
  output logic                MemWr,
  output logic                ExtOp,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [NPCOP_W-1:0]  NPCop,
  output logic [2:0]          state,
  output logic                trap,
  output logic                timeout,
  output logic [CNT_W-1:0]    retired_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMACC = 3'd3,
    S_WBACK  = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_ORI   = 4'b0100;
  localparam logic [3:0] ALU_ADDIU = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1111;

  localparam logic [3:0] NPC_JUMP = 4'b0000;
  localparam logic [3:0] NPC_BEQ  = 4'b0010;
  localparam logic [3:0] NPC_ADD4 = 4'b1111;

  // Watchdog holds the number of wait cycles already spent (0..TIMEOUT-1).
  localparam int             WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [5:0]       op_q;
  logic [5:0]       func_q;
  logic [WD_W-1:0]  wd_q;
  logic             trap_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;

  logic       lat_regdst;
  logic       lat_alusrc;
  logic       lat_extop;
  logic [3:0] lat_alu;
  logic [3:0] alu4;
  logic [3:0] npc4;
  logic       legal;

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    logic [3:0] a;
    case (f)
      FN_ADD:  a = ALU_ADD;
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_XOR:  a = ALU_XOR;
      FN_SLT:  a = ALU_SLT;
      FN_SLL:  a = ALU_SLL;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Legality of the live instruction word, used while in DECODE.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R: begin
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLL: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Datapath controls of the latched instruction, held from EXEC onward.
  always_comb begin
    lat_regdst = 1'b0;
    lat_alusrc = 1'b0;
    lat_extop  = 1'b0;
    lat_alu    = ALU_ADD;
    case (op_q)
      OP_R:    lat_alu = r_alu(func_q);
      OP_ADDI, OP_ADDIU: begin
        lat_regdst = 1'b1; lat_alusrc = 1'b1; lat_extop = 1'b1; lat_alu = ALU_ADDIU;
      end
      OP_ORI: begin
        lat_regdst = 1'b1; lat_alusrc = 1'b1; lat_extop = 1'b0; lat_alu = ALU_ORI;
      end
      OP_LUI: begin
        lat_regdst = 1'b1; lat_alusrc = 1'b1; lat_extop = 1'b1; lat_alu = ALU_LUI;
      end
      OP_LW, OP_SW: begin
        lat_regdst = 1'b1; lat_alusrc = 1'b1; lat_extop = 1'b1; lat_alu = ALU_ADD;
      end
      OP_BEQ:  lat_alu = ALU_SUB;
      default: lat_alu = ALU_ADD;
    endcase
  end

  // Output decode: Moore on state/latch, ready-gated PCWr/IRWr, beq uses zero.
  always_comb begin
    imem_rd  = 1'b0;
    dmem_rd  = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    ExtOp    = 1'b0;
    alu4     = ALU_ADD;
    npc4     = NPC_ADD4;
    if (state_q == S_EXEC || state_q == S_MEMACC || state_q == S_WBACK) begin
      RegDst = lat_regdst;
      ALUSrc = lat_alusrc;
      ExtOp  = lat_extop;
      alu4   = lat_alu;
    end
    case (state_q)
      S_FETCH: begin
        imem_rd = 1'b1;
        IRWr    = imem_ready;
      end
      S_DECODE: begin
        if (op == OP_J) begin
          PCWr = 1'b1;
          npc4 = NPC_JUMP;
        end
      end
      S_EXEC: begin
        if (op_q == OP_BEQ) begin
          PCWr = 1'b1;
          npc4 = zero ? NPC_BEQ : NPC_ADD4;
        end
      end
      S_MEMACC: begin
        dmem_rd = (op_q == OP_LW);
        MemWr   = (op_q == OP_SW);
        PCWr    = (op_q == OP_SW) && dmem_ready;
      end
      S_WBACK: begin
        RegWr    = 1'b1;
        PCWr     = 1'b1;
        MemtoReg = (op_q == OP_LW);
      end
      default: ;
    endcase
    if (rst) begin
      imem_rd = 1'b0;
      dmem_rd = 1'b0;
      IRWr    = 1'b0;
      PCWr    = 1'b0;
      RegWr   = 1'b0;
      MemWr   = 1'b0;
    end
  end

  // Sequencer: state, decode latch, watchdog, sticky trap flags, retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      func_q    <= '0;
      wd_q      <= '0;
      trap_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            wd_q    <= '0;
            state_q <= S_DECODE;
          end else if (wd_q == WD_LAST) begin
            wd_q      <= '0;
            trap_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_TRAP;
          end else begin
            wd_q <= wd_q + WD_ONE;
          end
        end
        S_DECODE: begin
          op_q   <= op;
          func_q <= func;
          if (!legal) begin
            trap_q  <= 1'b1;
            state_q <= S_TRAP;
          end else if (op == OP_J) begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= S_FETCH;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_q == OP_BEQ) begin
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= S_FETCH;
          end else if (op_q == OP_LW || op_q == OP_SW) begin
            state_q <= S_MEMACC;
          end else begin
            state_q <= S_WBACK;
          end
        end
        S_MEMACC: begin
          if (dmem_ready) begin
            wd_q <= '0;
            if (op_q == OP_LW) begin
              state_q <= S_WBACK;
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
              state_q <= S_FETCH;
            end
          end else if (wd_q == WD_LAST) begin
            wd_q      <= '0;
            trap_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_TRAP;
          end else begin
            wd_q <= wd_q + WD_ONE;
          end
        end
        S_WBACK: begin
          cnt_q   <= cnt_q + CNT_ONE;
          state_q <= S_FETCH;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign ALUctr      = ALUCTR_W'(alu4);
  assign NPCop       = NPCOP_W'(npc4);
  assign state       = state_q;
  assign trap        = trap_q;
  assign timeout     = timeout_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected cycle sequences built from
// the instruction rules, compared every cycle, plus literal latency/count pins.
module tb_mc_controller;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 3;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;

  typedef struct packed {
    logic [2:0] st;
    logic imem_rd, dmem_rd, irwr, pcwr, regdst, alusrc, memtoreg, regwr, memwr, extop;
    logic [3:0] aluctr;
    logic [3:0] npcop;
    logic trap, tmo;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0] op, func;
  logic zero, imem_ready, dmem_ready;
  logic imem_rd, dmem_rd, IRWr, PCWr, RegDst, ALUSrc, MemtoReg, RegWr, MemWr, ExtOp;
  logic [3:0] ALUctr, NPCop;
  logic [2:0] state;
  logic trap, timeout;
  logic [CNT_W-1:0] retired_cnt;

  mc_controller #(.ALUCTR_W(4), .NPCOP_W(4), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_rd(imem_rd), .dmem_rd(dmem_rd), .IRWr(IRWr), .PCWr(PCWr),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWr(RegWr),
    .MemWr(MemWr), .ExtOp(ExtOp), .ALUctr(ALUctr), .NPCop(NPCop),
    .state(state), .trap(trap), .timeout(timeout), .retired_cnt(retired_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;
  int ncyc;
  logic [EXP_W-1:0] exp_q[$];

  // model state
  int   m_cnt;
  logic m_trap, m_tmo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // scoreboard: one expected vector per cycle, checked on the falling edge
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        a = '{state, imem_rd, dmem_rd, IRWr, PCWr, RegDst, ALUSrc, MemtoReg,
              RegWr, MemWr, ExtOp, ALUctr, NPCop, trap, timeout, retired_cnt};
        n_total++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle_cmp t=%0t st=%0d got=%h want=%h", $time, state, a, e);
        end
      end
    end
  end

  function automatic exp_t idle_exp(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.aluctr = 4'b0010;
    e.npcop = 4'b1111;
    e.trap = m_trap;
    e.tmo = m_tmo;
    e.cnt = CNT_W'(m_cnt);
    return e;
  endfunction

  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
    if (o == OP_R)
      return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 ||
              f == 6'h26 || f == 6'h2a || f == 6'h00);
    return (o == OP_ADDI || o == OP_ADDIU || o == OP_ORI || o == OP_LUI ||
            o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J);
  endfunction

  // controls an instruction presents from EXEC onward
  function automatic exp_t with_exec(input exp_t e, input logic [5:0] o, input logic [5:0] f);
    exp_t r;
    r = e;
    case (o)
      OP_R: begin
        case (f)
          6'h20: r.aluctr = 4'b0010;
          6'h22: r.aluctr = 4'b0110;
          6'h24: r.aluctr = 4'b0000;
          6'h25: r.aluctr = 4'b0001;
          6'h26: r.aluctr = 4'b0011;
          6'h2a: r.aluctr = 4'b0111;
          default: r.aluctr = 4'b1000;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin r.regdst = 1; r.alusrc = 1; r.extop = 1; r.aluctr = 4'b0101; end
      OP_ORI:  begin r.regdst = 1; r.alusrc = 1; r.extop = 0; r.aluctr = 4'b0100; end
      OP_LUI:  begin r.regdst = 1; r.alusrc = 1; r.extop = 1; r.aluctr = 4'b1111; end
      OP_LW, OP_SW: begin r.regdst = 1; r.alusrc = 1; r.extop = 1; r.aluctr = 4'b0010; end
      default: r.aluctr = 4'b0110;  // beq
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic push(input exp_t e);
    exp_q.push_back(e);
  endtask

  task automatic retire();
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic trap_tail(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      op = 6'($urandom_range(0, 63));
      func = 6'($urandom_range(0, 63));
      push(idle_exp(3'd5));
      tick();
    end
  endtask

  // driver + model for one instruction; iw/dw = wait cycles before ready
  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                          input int iw, input int dw);
    exp_t e;
    ncyc = 0;
    op = o; func = f; zero = z;
    dmem_ready = 1'b1;
    for (int k = 0; k <= TIMEOUT; k++) begin
      imem_ready = (k == iw);
      e = idle_exp(3'd0);
      e.imem_rd = 1'b1;
      e.irwr = (k == iw);
      push(e);
      tick();
      if (k == iw) break;
      if (k + 1 == TIMEOUT) begin
        m_trap = 1; m_tmo = 1;
        trap_tail(3);
        return;
      end
    end
    // DECODE
    imem_ready = 1'b1;
    e = idle_exp(3'd1);
    if (!is_legal(o, f)) begin
      push(e); tick();
      m_trap = 1;
      trap_tail(3);
      return;
    end
    if (o == OP_J) begin
      e.pcwr = 1; e.npcop = 4'b0000;
      push(e); tick(); retire();
      return;
    end
    push(e); tick();
    op = 6'($urandom_range(0, 63));
    func = 6'($urandom_range(0, 63));
    // EXEC
    e = with_exec(idle_exp(3'd2), o, f);
    if (o == OP_BEQ) begin
      e.pcwr = 1; e.npcop = z ? 4'b0010 : 4'b1111;
      push(e); tick(); retire();
      return;
    end
    push(e); tick();
    // MEMACC
    if (o == OP_LW || o == OP_SW) begin
      for (int k = 0; k <= TIMEOUT; k++) begin
        dmem_ready = (k == dw);
        e = with_exec(idle_exp(3'd3), o, f);
        e.dmem_rd = (o == OP_LW);
        e.memwr = (o == OP_SW);
        e.pcwr = (o == OP_SW) && (k == dw);
        push(e); tick();
        if (k == dw) begin
          if (o == OP_SW) begin
            retire();
            return;
          end
          break;
        end
        if (k + 1 == TIMEOUT) begin
          m_trap = 1; m_tmo = 1;
          trap_tail(3);
          return;
        end
      end
    end
    // WBACK
    dmem_ready = 1'b1;
    e = with_exec(idle_exp(3'd4), o, f);
    e.regwr = 1; e.pcwr = 1;
    e.memtoreg = (o == OP_LW);
    push(e); tick(); retire();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    #1;
    check("rst_imem_rd", 32'(imem_rd), 0);
    check("rst_enables", {IRWr, PCWr, RegWr, MemWr, dmem_rd}, 0);
    tick();
    tick();
    rst = 1'b0;
    imem_ready = 1'b0;
    m_cnt = 0; m_trap = 0; m_tmo = 0;
    check("rst_state", 32'(state), 0);
    check("rst_flags", {trap, timeout}, 0);
    check("rst_cnt", 32'(retired_cnt), 0);
  endtask

  // directed stimulus
  initial begin
    logic [5:0] fns [6];
    logic [5:0] iops[4];
    rst = 1'b1; op = '0; func = '0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    m_cnt = 0; m_trap = 0; m_tmo = 0;
    fns  = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h00};
    iops = '{OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI};
    @(posedge clk); #1;
    do_reset();

    do_instr(OP_R, 6'h20, 1'b1, 0, 0);
    check("add_cycles", ncyc, 4);
    check("add_cnt", 32'(retired_cnt), 1);
    do_instr(OP_LW, 6'h15, 1'b0, 0, 3);
    check("lw_wait_cycles", ncyc, 8);
    check("lw_cnt", 32'(retired_cnt), 2);
    do_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    check("beq_taken_cycles", ncyc, 3);
    do_instr(OP_BEQ, 6'h00, 1'b0, 0, 0);
    check("beq_not_cycles", ncyc, 3);
    do_instr(OP_J, 6'h3f, 1'b0, 0, 0);
    check("j_cycles", ncyc, 2);
    check("j_cnt", 32'(retired_cnt), 5);
    do_instr(OP_SW, 6'h01, 1'b0, 1, 1);
    check("sw_wait_cycles", ncyc, 6);
    for (int i = 0; i < 6; i++) begin
      do_instr(OP_R, fns[i], 1'b1, 0, 0);
      check("rtype_cycles", ncyc, 4);
    end
    for (int i = 0; i < 4; i++) begin
      do_instr(iops[i], 6'h2a, 1'b1, 0, 0);
      check("itype_cycles", ncyc, 4);
    end
    check("cnt_wrap", 32'(retired_cnt), 0);
    do_instr(OP_LW, 6'h00, 1'b0, 0, 0);
    check("lw_cycles", ncyc, 5);

    // ready at the watchdog limit still makes progress
    do_instr(OP_R, 6'h20, 1'b0, TIMEOUT - 1, 0);
    check("ready_at_limit_cycles", ncyc, 4 + TIMEOUT - 1);
    check("ready_at_limit_trap", 32'(trap), 0);
    check("ready_at_limit_cnt", 32'(retired_cnt), 2);

    // fetch watchdog
    do_instr(OP_R, 6'h20, 1'b0, 99, 0);
    check("fetch_to_state", 32'(state), 5);
    check("fetch_to_flags", {trap, timeout}, 2'b11);
    check("fetch_to_cnt_frozen", 32'(retired_cnt), 2);
    do_reset();

    do_instr(6'b111111, 6'h20, 1'b0, 0, 0);
    check("bad_op_state", 32'(state), 5);
    check("bad_op_flags", {trap, timeout}, 2'b10);
    do_reset();
    do_instr(OP_R, 6'b001000, 1'b0, 0, 0);
    check("bad_func_flags", {trap, timeout}, 2'b10);
    do_reset();

    // data watchdog
    do_instr(OP_SW, 6'h00, 1'b0, 0, 99);
    check("dmem_to_flags", {trap, timeout}, 2'b11);
    do_reset();

    // reset during WBACK
    op = OP_R; func = 6'h20; imem_ready = 1'b1;
    tick(); tick(); tick();
    check("mid_wback_state", 32'(state), 4);
    rst = 1'b1; #1;
    check("mid_wback_en", {PCWr, RegWr, MemWr}, 0);
    tick();
    rst = 1'b0;
    check("mid_wback_after", {29'(state), trap, timeout}, 0);

    // reset during MEMACC of lw
    op = OP_LW; dmem_ready = 1'b0; imem_ready = 1'b1;
    tick(); tick(); tick();
    check("mid_mem_state", 32'(state), 3);
    check("mid_mem_rd", 32'(dmem_rd), 1);
    rst = 1'b1; #1;
    check("mid_mem_en", {dmem_rd, PCWr, RegWr, MemWr}, 0);
    tick();
    rst = 1'b0;
    check("mid_mem_after", 32'(state), 0);

    tick(); tick();
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    n_bad++;
    $display("FAIL sim_time_limit: got expired want finished");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
